// File: rtl/play_seq_ctrl.sv
// Playback sequencer: stop/play/pause state, note-step divider and
// one-cycle strobes for the track and note counters. Every output is
// registered; the combinational block computes next state and next strobes.
module play_seq_ctrl #(
   parameter int TICK_DIV   = 12500000,
   parameter int NUM_TRACKS = 4
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          btn_play,
   input  logic                          btn_stop,
   input  logic                          btn_next,
   input  logic                          btn_prev,
   input  logic                          loop_all,
   input  logic                          note_last,
   input  logic [$clog2(NUM_TRACKS)-1:0] trk_idx,
   output logic                          trk_ena,
   output logic                          trk_inc,
   output logic                          trk_dec,
   output logic                          note_ena,
   output logic                          note_rst,
   output logic                          playing,
   output logic                          paused
);

   localparam int DW = $clog2(TICK_DIV);
   localparam int W  = $clog2(NUM_TRACKS);

   typedef enum logic [1:0] {S_IDLE, S_PLAY, S_PAUSE} state_t;

   state_t          r_state, w_nxt_state;
   logic [DW-1:0]   r_div, w_nxt_div;
   logic            w_tick, w_last_trk;
   logic            w_inc, w_dec, w_note_ena, w_note_rst;
   logic            r_trk_ena, r_trk_inc, r_trk_dec;
   logic            r_note_ena, r_note_rst, r_playing, r_paused;

   assign w_tick     = (r_state == S_PLAY) && (r_div == DW'(TICK_DIV - 1));
   assign w_last_trk = (trk_idx == W'(NUM_TRACKS - 1));

   // Next state, divider and strobes; only the highest-priority event
   // (stop > next > prev > play > tick) is acted on, the rest are dropped.
   always_comb begin
      w_nxt_state = r_state;
      w_nxt_div   = r_div;
      w_inc       = 1'b0;
      w_dec       = 1'b0;
      w_note_ena  = 1'b0;
      w_note_rst  = 1'b0;
      if (btn_stop) begin
         w_nxt_state = S_IDLE;
         w_nxt_div   = '0;
         w_note_rst  = 1'b1;
      end else if (btn_next) begin
         w_inc      = 1'b1;
         w_note_rst = 1'b1;
         w_nxt_div  = '0;
      end else if (btn_prev) begin
         w_dec      = 1'b1;
         w_note_rst = 1'b1;
         w_nxt_div  = '0;
      end else if (btn_play) begin
         // Play/pause toggles keep the divider so resume finishes the
         // partial step; a fresh start from IDLE begins a full step.
         case (r_state)
            S_IDLE:  begin w_nxt_state = S_PLAY; w_nxt_div = '0; end
            S_PLAY:  w_nxt_state = S_PAUSE;
            default: w_nxt_state = S_PLAY;
         endcase
      end else if (w_tick) begin
         w_nxt_div = '0;
         if (!note_last) begin
            w_note_ena = 1'b1;
         end else if (!w_last_trk || loop_all) begin
            w_note_rst = 1'b1;
            w_inc      = 1'b1;
         end else begin
            // End of the final track without looping: stop playback.
            w_note_rst  = 1'b1;
            w_nxt_state = S_IDLE;
         end
      end else if (r_state == S_PLAY) begin
         w_nxt_div = r_div + DW'(1);
      end
   end

   // State and divider registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= S_IDLE;
         r_div   <= '0;
      end else begin
         r_state <= w_nxt_state;
         r_div   <= w_nxt_div;
      end
   end

   // Registered outputs: strobes appear one edge after their cause.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_trk_ena  <= 1'b0;
         r_trk_inc  <= 1'b0;
         r_trk_dec  <= 1'b0;
         r_note_ena <= 1'b0;
         r_note_rst <= 1'b0;
         r_playing  <= 1'b0;
         r_paused   <= 1'b0;
      end else begin
         r_trk_ena  <= w_inc | w_dec;
         r_trk_inc  <= w_inc;
         r_trk_dec  <= w_dec;
         r_note_ena <= w_note_ena;
         r_note_rst <= w_note_rst;
         r_playing  <= (w_nxt_state == S_PLAY);
         r_paused   <= (w_nxt_state == S_PAUSE);
      end
   end

   assign trk_ena  = r_trk_ena;
   assign trk_inc  = r_trk_inc;
   assign trk_dec  = r_trk_dec;
   assign note_ena = r_note_ena;
   assign note_rst = r_note_rst;
   assign playing  = r_playing;
   assign paused   = r_paused;

endmodule

// File: doc/play_seq_ctrl.md
Name: play_seq_ctrl

Overview:
Playback sequencer for the music player. It holds the stop/play/pause state and converts button pulses into one-cycle control strobes for the two mod-N counters in the datapath: the track counter and the note counter. It also generates the note-step tick in PLAY and advances the track automatically at end of track. It sits between the debounced button logic and the counter instances.

Parameters:
TICK_DIV, 12500000, clock cycles per note step; must be >= 2; the divider width is $clog2(TICK_DIV).
NUM_TRACKS, 4, number of tracks; sets the trk_idx width W = $clog2(NUM_TRACKS) and defines the last track as NUM_TRACKS-1.

Ports:
clk  in  1  system clock, rising edge.
rst  in  1  asynchronous, active-high reset.
btn_play  in  1  single-cycle pulse; toggles play/pause.
btn_stop  in  1  single-cycle pulse; stop.
btn_next  in  1  single-cycle pulse; next track.
btn_prev  in  1  single-cycle pulse; previous track.
loop_all  in  1  level; 1 = wrap to track 0 after the last track.
note_last  in  1  level from the note counter; current note is the last note of the track.
trk_idx  in  W  current track-counter value.
trk_ena  out  1  track counter enable strobe.
trk_inc  out  1  track counter increment strobe.
trk_dec  out  1  track counter decrement strobe.
note_ena  out  1  note counter step strobe.
note_rst  out  1  note counter synchronous clear strobe.
playing  out  1  state == PLAY.
paused  out  1  state == PAUSE.

Behaviour:
- All outputs are registered. On rst: state = IDLE, divider = 0, and every output = 0. rst asserted mid-operation aborts immediately, including any pulse in flight.
- States and transitions:
  - IDLE -> PLAY on btn_play.
  - PLAY -> PAUSE on btn_play.
  - PAUSE -> PLAY on btn_play.
  - IDLE/PLAY/PAUSE -> IDLE on btn_stop.
- playing and paused are updated on the same edge as the state change; they are never both 1.
- All strobes are high for exactly one cycle, on the edge after the cause (1-cycle latency).
- trk_inc and trk_dec are never high together. trk_ena = trk_inc | trk_dec.
- Divider:
  - Counts 0..TICK_DIV-1 only in PLAY.
  - Holds its value in PAUSE, so resume continues the partial step.
  - Clears to 0 on entering IDLE and on any accepted next/prev.
  - Clears to 0 on IDLE -> PLAY.
  - A tick occurs on a PLAY cycle with divider == TICK_DIV-1; the next edge sets divider to 0 and performs the tick action.
- Tick action:
  - note_last = 0: note_ena = 1.
  - note_last = 1 and (trk_idx != NUM_TRACKS-1 or loop_all = 1): note_rst = 1, trk_ena = 1, trk_inc = 1; stay in PLAY.
  - note_last = 1, trk_idx == NUM_TRACKS-1, loop_all = 0: note_rst = 1, no track strobe, state -> IDLE.
- btn_stop: note_rst = 1; the track is unchanged.
- btn_next: trk_ena = 1, trk_inc = 1, note_rst = 1; state unchanged in any state. It is issued even at the last track regardless of loop_all; the counter wraps.
- btn_prev: trk_ena = 1, trk_dec = 1, note_rst = 1; state unchanged. At track 0 the counter wraps to NUM_TRACKS-1.
- Simultaneous events:
  - Priority is btn_stop > btn_next > btn_prev > btn_play > tick.
  - Only the highest-priority event is acted on in a cycle; lower-priority events are dropped, not queued.
  - A tick coinciding with any accepted button is discarded, and the divider follows the button rule.
- btn_play in IDLE does not pulse note_rst; playback resumes from the current note position.

Test Plan:
- TICK_DIV=4, NUM_TRACKS=4. Reset, then btn_play -> playing=1 on the next edge; note_ena pulses every 4 cycles, 1 cycle wide; trk_* stay 0.
- PLAY with divider at 2, btn_play -> paused=1 and no note_ena while paused; btn_play again -> first note_ena exactly 2 cycles after resume.
- PLAY, trk_idx=1, note_last=1 at a tick -> single cycle with note_rst=1, trk_ena=1, trk_inc=1, note_ena=0; playing stays 1.
- trk_idx=3, note_last=1, loop_all=0 at a tick -> note_rst=1, trk_ena=0, next state IDLE. Repeat with loop_all=1 -> trk_inc=1 and still playing.
- btn_stop, btn_next and tick on the same cycle -> only note_rst=1, state IDLE, trk_ena=0. Separately, btn_prev in PAUSE -> trk_dec=1, note_rst=1, still paused, divider 0.
- rst asserted asynchronously between edges while trk_ena=1 -> all outputs 0 immediately, state IDLE; after release, btn_play gives the first note_ena 4 cycles after playing rises.
